pc_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM's 8-bit byte address.
- Captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake.
- Applies branch redirects from the execute stage and halts on the ROM's null word.

---
 rtl/pc_fetch_unit_pkg.sv | 17 +
 rtl/pc_fetch_unit_pc_reg.sv | 43 ++++
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, PC step, null-word encoding and
// the fetch state encoding.
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_STEP = 4;

  // The ROM returns this word past the end of the program; fetch stops on it.
  localparam logic [DATA_W-1:0] INST_NOP_NULL = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register with +PC_STEP incrementer and redirect mux.
// Redirect targets are forced to word alignment (low two bits cleared).
// Ports:
//   clk, rst_n   clock, async active-low reset (PC <- RESET_PC)
//   advance_i    step the PC by PC_STEP (modulo 2^ADDR_W)
//   redirect_i   load the aligned target (wins over advance_i)
//   target_i     redirect byte address
//   pc_o         current PC
module pc_fetch_unit_pc_reg #(
  parameter int unsigned      ADDR_W   = pc_fetch_unit_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);
  import pc_fetch_unit_pkg::*;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // Next PC: redirect > advance > hold
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i & ALIGN_MASK;
    end else if (advance_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: drives the ROM address from the PC, captures the
// returned word into an IF/ID register with valid/ready, applies branch
// redirects and halts on the ROM's null word.
// Optional macro BR_MISALIGN_TRAP_EN: adds misalign_o; a branch to a
// non-word-aligned target traps into HALT instead of redirecting.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   imem_addr_o/imem_data_i ROM address (the PC) / combinational read data
//   br_taken_i/br_target_i  redirect request / byte target
//   inst_o, pc_o, valid_o   IF/ID register, handshaked with ready_i
//   halt_o                  fetch stopped on a null word
//   misalign_o              (macro only) misaligned branch trapped
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = pc_fetch_unit_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = pc_fetch_unit_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_data_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              halt_o
`ifdef BR_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);
  import pc_fetch_unit_pkg::*;

  fetch_state_t      state_d, state_q;
  logic [DATA_W-1:0] inst_d, inst_q;
  logic [ADDR_W-1:0] pc_out_d, pc_out_q;
  logic              valid_d, valid_q;
  logic              halt_d, halt_q;
  logic [ADDR_W-1:0] pc_c;
  logic              load_c;
  logic              advance_c;
  logic              redirect_c;
`ifdef BR_MISALIGN_TRAP_EN
  logic              misalign_d, misalign_q;
`endif

  pc_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance_i  (advance_c),
    .redirect_i (redirect_c),
    .target_i   (br_target_i),
    .pc_o       (pc_c)
  );

  // Output register is free when empty or being drained this cycle
  assign load_c = !valid_q || ready_i;

  // Next-state / IF/ID capture: branch > stall > null-word halt > advance
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    advance_c  = 1'b0;
    redirect_c = 1'b0;
`ifdef BR_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (br_taken_i) begin
`ifdef BR_MISALIGN_TRAP_EN
      if (br_target_i[1:0] != 2'b00) begin
        // Trap: PC keeps its value, fetch parks in HALT
        misalign_d = 1'b1;
        state_d    = HALT;
        halt_d     = 1'b1;
        valid_d    = 1'b0;
      end else begin
        misalign_d = 1'b0;
        redirect_c = 1'b1;
        state_d    = RUN;
        halt_d     = 1'b0;
        valid_d    = 1'b0;
      end
`else
      redirect_c = 1'b1;
      state_d    = RUN;
      halt_d     = 1'b0;
      valid_d    = 1'b0;
`endif
    end else if (state_q == RUN) begin
      if (load_c) begin
        if (imem_data_i == DATA_W'(INST_NOP_NULL)) begin
          state_d = HALT;
          halt_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          inst_d    = imem_data_i;
          pc_out_d  = pc_c;
          valid_d   = 1'b1;
          advance_c = 1'b1;
        end
      end
    end else begin
      // HALT: drain any word still held, capture nothing new
      valid_d = valid_q && !ready_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inst_q     <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
`ifdef BR_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
`ifdef BR_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_addr_o = pc_c;
  assign inst_o      = inst_q;
  assign pc_o        = pc_out_q;
  assign valid_o     = valid_q;
  assign halt_o      = halt_q;
`ifdef BR_MISALIGN_TRAP_EN
  assign misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: ROM model, scenario tasks with inline checks and
// a scoreboard of accepted IF/ID transfers.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] inst;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic        br_taken_i = 1'b0;
  logic [7:0]  br_target_i = 8'h00;
  logic [31:0] inst_o;
  logic [7:0]  pc_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        halt_o;
`ifdef BR_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  logic [31:0] rom [64];
  txn_t        exp_q[$];
  txn_t        act_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .halt_o      (halt_o)
`ifdef BR_MISALIGN_TRAP_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  assign imem_data_i = rom[imem_addr_o[7:2]];

  // Record every transfer that will complete at the coming rising edge
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) act_q.push_back({pc_o, inst_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n = 1'b0; ready_i = 1'b1; br_taken_i = 1'b0;
    step(); step();
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== 18'h0 || inst_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_state: got v/h/pc/addr=%h inst=%h want 0/0", obs, inst_o);
    end
    rst_n = 1'b1;
    step();
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== {2'b10, 8'h00, 8'h04} || inst_o !== 32'h00700093) begin
      n_bad++; $display("FAIL first_fetch: got v/h/pc/addr=%h inst=%h want %h inst=00700093",
                        obs, inst_o, {2'b10, 8'h00, 8'h04});
    end
    exp_q.push_back({8'h00, 32'h00700093});
  endtask

  task automatic test_stall();
    logic [17:0] obs;
    step();
    exp_q.push_back({8'h04, 32'h00300193});
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {valid_o, halt_o, pc_o, imem_addr_o};
      n_cmp++;
      if (obs !== {2'b10, 8'h04, 8'h08} || inst_o !== 32'h00300193) begin
        n_bad++; $display("FAIL stall_hold_%0d: got v/h/pc/addr=%h inst=%h want %h inst=00300193",
                          i, obs, inst_o, {2'b10, 8'h04, 8'h08});
      end
    end
    ready_i = 1'b1;
    step();
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== {2'b10, 8'h08, 8'h0C} || inst_o !== 32'h00208233) begin
      n_bad++; $display("FAIL stall_release: got v/h/pc/addr=%h inst=%h want %h inst=00208233",
                        obs, inst_o, {2'b10, 8'h08, 8'h0C});
    end
    exp_q.push_back({8'h08, 32'h00208233});
  endtask

  task automatic test_branch_flush();
    logic [17:0] obs;
    step(); exp_q.push_back({8'h0C, 32'h00110113});
    step(); exp_q.push_back({8'h10, 32'h00418193});
    step(); exp_q.push_back({8'h14, 32'h00520213});
    n_cmp++;
    if (imem_addr_o !== 8'h18) begin
      n_bad++; $display("FAIL branch_pre_addr: got %h want 18", imem_addr_o);
    end
    br_taken_i = 1'b1; br_target_i = 8'h0C;
    step();
    br_taken_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || imem_addr_o !== 8'h0C) begin
      n_bad++; $display("FAIL branch_flush: got valid=%b addr=%h want valid=0 addr=0C", valid_o, imem_addr_o);
    end
    step();
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== {2'b10, 8'h0C, 8'h10} || inst_o !== 32'h00110113) begin
      n_bad++; $display("FAIL branch_refetch: got v/h/pc/addr=%h inst=%h want %h inst=00110113",
                        obs, inst_o, {2'b10, 8'h0C, 8'h10});
    end
    exp_q.push_back({8'h0C, 32'h00110113});
  endtask

  task automatic test_null_halt();
    logic [17:0] obs;
    step(); exp_q.push_back({8'h10, 32'h00418193});
    step(); exp_q.push_back({8'h14, 32'h00520213});
    step(); exp_q.push_back({8'h18, 32'h00628293});
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {valid_o, halt_o, pc_o, imem_addr_o};
      n_cmp++;
      if (obs[17:16] !== 2'b01 || imem_addr_o !== 8'h1C) begin
        n_bad++; $display("FAIL null_halt_%0d: got valid=%b halt=%b addr=%h want 0/1/1C",
                          i, valid_o, halt_o, imem_addr_o);
      end
    end
    br_taken_i = 1'b1; br_target_i = 8'h00;
    step();
    br_taken_i = 1'b0;
    n_cmp++;
    if (halt_o !== 1'b0 || valid_o !== 1'b0 || imem_addr_o !== 8'h00) begin
      n_bad++; $display("FAIL halt_exit: got halt=%b valid=%b addr=%h want 0/0/00", halt_o, valid_o, imem_addr_o);
    end
    step();
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== {2'b10, 8'h00, 8'h04} || inst_o !== 32'h00700093) begin
      n_bad++; $display("FAIL halt_refetch: got v/h/pc/addr=%h inst=%h want %h inst=00700093",
                        obs, inst_o, {2'b10, 8'h00, 8'h04});
    end
    exp_q.push_back({8'h00, 32'h00700093});
  endtask

  task automatic test_wrap_async_reset();
    logic [17:0] obs;
    br_taken_i = 1'b1; br_target_i = 8'hFC;
    step();
    br_taken_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || imem_addr_o !== 8'hFC) begin
      n_bad++; $display("FAIL wrap_branch: got valid=%b addr=%h want 0/FC", valid_o, imem_addr_o);
    end
    step();
    ready_i = 1'b0;
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== {2'b10, 8'hFC, 8'h00} || inst_o !== 32'hFC0000EF) begin
      n_bad++; $display("FAIL wrap_fetch: got v/h/pc/addr=%h inst=%h want %h inst=FC0000EF",
                        obs, inst_o, {2'b10, 8'hFC, 8'h00});
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {valid_o, halt_o, pc_o, imem_addr_o};
    n_cmp++;
    if (obs !== 18'h0 || inst_o !== 32'h0) begin
      n_bad++; $display("FAIL async_reset: got v/h/pc/addr=%h inst=%h want 0/0", obs, inst_o);
    end
    ready_i = 1'b1;
  endtask

  task automatic test_scoreboard();
    txn_t a, e;
    n_cmp++;
    if (act_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL sb_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_bad++; $display("FAIL sb_txn: got pc=%h inst=%h want pc=%h inst=%h", a.pc, a.inst, e.pc, e.inst);
      end
    end
  endtask

`ifdef BR_MISALIGN_TRAP_EN
  task automatic test_misalign();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready_i = 1'b0;
    br_taken_i = 1'b1; br_target_i = 8'h0E;
    step();
    n_cmp++;
    if (misalign_o !== 1'b1 || halt_o !== 1'b1 || valid_o !== 1'b0 || imem_addr_o !== 8'h00) begin
      n_bad++; $display("FAIL misalign_trap: got mis=%b halt=%b valid=%b addr=%h want 1/1/0/00",
                        misalign_o, halt_o, valid_o, imem_addr_o);
    end
    br_target_i = 8'h08;
    step();
    br_taken_i = 1'b0;
    n_cmp++;
    if (misalign_o !== 1'b0 || halt_o !== 1'b0 || imem_addr_o !== 8'h08) begin
      n_bad++; $display("FAIL misalign_clear: got mis=%b halt=%b addr=%h want 0/0/08",
                        misalign_o, halt_o, imem_addr_o);
    end
    step();
    n_cmp++;
    if (valid_o !== 1'b1 || pc_o !== 8'h08 || inst_o !== 32'h00208233) begin
      n_bad++; $display("FAIL misalign_fetch: got valid=%b pc=%h inst=%h want 1/08/00208233",
                        valid_o, pc_o, inst_o);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0]  = 32'h00700093;
    rom[1]  = 32'h00300193;
    rom[2]  = 32'h00208233;
    rom[3]  = 32'h00110113;
    rom[4]  = 32'h00418193;
    rom[5]  = 32'h00520213;
    rom[6]  = 32'h00628293;
    rom[7]  = 32'h00000000;
    rom[63] = 32'hFC0000EF;

    test_reset();
    test_stall();
    test_branch_flush();
    test_null_halt();
    test_wrap_async_reset();
    test_scoreboard();
`ifdef BR_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
